// File: rtl/store_unit_if.sv
// Write-bus interface between store_unit (master) and data memory (slave).
// Valid/ready handshake carrying a word-aligned address, write data and byte enables.
interface store_unit_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready
    );
endinterface

// File: rtl/store_unit.sv
// store_unit: turns a core store request (SB/SH/SW) into a byte-enabled write on
// the memory bus, stalls the core until accepted, and flags misaligned/illegal
// stores and bus timeouts.
// Optional feature macro: MISALIGN_SPLIT_EN -- misaligned SH/SW are split into two
// aligned word writes (ISSUE then ISSUE2) instead of being rejected.
module store_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st_req,
    input  logic [31:0]         st_addr,
    input  logic [31:0]         st_data,
    input  logic [2:0]          st_funct3,
    output logic                st_busy,
    output logic                st_done,
    output logic                st_err,
    store_unit_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1
`ifdef MISALIGN_SPLIT_EN
        ,
        ISSUE2 = 2'd2
`endif
    } state_t;

    // Counter only ever holds 0..TIMEOUT_CYC-1; the abort fires on the edge that would reach TIMEOUT_CYC.
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [31:0]    addr_reg, addr_next;
    logic [31:0]    wdata_reg, wdata_next;
    logic [3:0]     be_reg, be_next;
    logic           done_reg, done_next;
    logic           err_reg, err_next;

    // Request decode
    logic [1:0]     lane;
    logic [3:0]     size_mask;
    logic [31:0]    repl_data;
    logic           f3_ok;
    logic           aligned;
    logic           legal;
    logic [3:0]     first_be;
    logic [31:0]    first_data;
    logic           timeout_hit;

`ifdef MISALIGN_SPLIT_EN
    logic [31:0]    hi_data_reg, hi_data_next;
    logic [3:0]     hi_be_reg, hi_be_next;
    logic [31:0]    raw_data;
    logic [63:0]    shifted_data;
    logic [7:0]     shifted_be;
`endif

    assign lane = st_addr[1:0];

    // Lane selection and data replication for the incoming request
    always_comb begin
        size_mask = 4'b0000;
        repl_data = 32'h0;
        f3_ok     = 1'b1;
        aligned   = 1'b1;
        case (st_funct3)
            3'b000: begin
                size_mask = 4'b0001;
                repl_data = {4{st_data[7:0]}};
            end
            3'b001: begin
                size_mask = 4'b0011;
                repl_data = {2{st_data[15:0]}};
                aligned   = ~lane[0];
            end
            3'b010: begin
                size_mask = 4'b1111;
                repl_data = st_data;
                aligned   = (lane == 2'b00);
            end
            default: begin
                f3_ok   = 1'b0;
                aligned = 1'b0;
            end
        endcase
    end

`ifdef MISALIGN_SPLIT_EN
    // Misaligned accesses: shift bytes into place across two consecutive words
    always_comb begin
        raw_data     = (st_funct3 == 3'b001) ? {16'h0, st_data[15:0]} : st_data;
        shifted_data = {32'h0, raw_data} << {lane, 3'b000};
        shifted_be   = {4'b0000, size_mask} << lane;
        legal        = f3_ok;
        first_be     = shifted_be[3:0];
        first_data   = aligned ? repl_data : shifted_data[31:0];
    end
`else
    // Only naturally aligned accesses are accepted
    always_comb begin
        legal      = f3_ok & aligned;
        first_be   = size_mask << lane;
        first_data = repl_data;
    end
`endif

    assign timeout_hit = (TIMEOUT_CYC != 0) && !bus.mem_ready && (cnt_reg == TO_LAST);

    // Next-state and datapath-next logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        hi_data_next = hi_data_reg;
        hi_be_next   = hi_be_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (st_req) begin
                    if (legal) begin
                        state_next = ISSUE;
                        cnt_next   = '0;
                        addr_next  = {st_addr[31:2], 2'b00};
                        wdata_next = first_data;
                        be_next    = first_be;
`ifdef MISALIGN_SPLIT_EN
                        hi_data_next = shifted_data[63:32];
                        hi_be_next   = shifted_be[7:4];
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    cnt_next = '0;
`ifdef MISALIGN_SPLIT_EN
                    if (hi_be_reg != 4'b0000) begin
                        state_next = ISSUE2;
                        addr_next  = addr_reg + 32'd4;
                        wdata_next = hi_data_reg;
                        be_next    = hi_be_reg;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
`else
                    state_next = IDLE;
                    done_next  = 1'b1;
`endif
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ISSUE2: begin
                if (bus.mem_ready) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            be_reg    <= 4'h0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            hi_data_reg <= 32'h0;
            hi_be_reg   <= 4'h0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
`ifdef MISALIGN_SPLIT_EN
            hi_data_reg <= hi_data_next;
            hi_be_reg   <= hi_be_next;
`endif
        end
    end

    // Outputs: bus valid follows the state, stall also covers the accepting cycle
    always_comb begin
        st_busy = (state_reg != IDLE) | (st_req & legal);
    end

    assign bus.mem_valid = (state_reg != IDLE);
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.mem_be    = be_reg;
    assign st_done       = done_reg;
    assign st_err        = err_reg;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit (TIMEOUT_CYC=16).
module tb_store_unit;
    logic        clk;
    logic        rst;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_busy;
    logic        st_done;
    logic        st_err;
    int          checks;
    int          failures;
    int          hs_cnt;
    int          hs_base;
    int          nvalid;

    store_unit_if bus();

    store_unit #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_funct3 (st_funct3),
        .st_busy   (st_busy),
        .st_done   (st_done),
        .st_err    (st_err),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted bus handshakes
    always @(posedge clk) begin
        if (rst) hs_cnt <= 0;
        else if (bus.mem_valid && bus.mem_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        st_req    = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f;
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        st_req    = 1'b0;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        st_funct3 = 3'b000;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_be", {28'h0, bus.mem_be}, 32'h0);
        chk("rst_done_err_busy", {29'h0, st_done, st_err, st_busy}, 32'h0);
        rst = 1'b0;
        tick();

        // SW aligned, ready immediately
        bus.mem_ready = 1'b1;
        req(32'h100, 32'hDEADBEEF, 3'b010);
        chk("sw_busy_t", {31'h0, st_busy}, 32'h1);
        tick();
        st_req = 1'b0;
        #1;
        $display("txn SW addr=%h be=%b wdata=%h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
        chk("sw_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("sw_addr", bus.mem_addr, 32'h100);
        chk("sw_be", {28'h0, bus.mem_be}, 32'hF);
        chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("sw_busy_t1", {31'h0, st_busy}, 32'h1);
        tick();
        chk("sw_done", {30'h0, st_done, st_err}, 32'h2);
        chk("sw_idle", {30'h0, bus.mem_valid, st_busy}, 32'h0);
        tick();
        chk("sw_done_pulse", {31'h0, st_done}, 32'h0);

        // SB to byte lane 3
        req(32'h203, 32'h000000A5, 3'b000);
        tick();
        st_req = 1'b0;
        $display("txn SB addr=%h be=%b wdata=%h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
        chk("sb_addr", bus.mem_addr, 32'h200);
        chk("sb_be", {28'h0, bus.mem_be}, 32'h8);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        tick();
        chk("sb_done", {31'h0, st_done}, 32'h1);

        // SH to upper half
        req(32'h202, 32'h00001234, 3'b001);
        tick();
        st_req = 1'b0;
        $display("txn SH addr=%h be=%b wdata=%h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
        chk("sh_addr", bus.mem_addr, 32'h200);
        chk("sh_be", {28'h0, bus.mem_be}, 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'h12341234);
        tick();
        chk("sh_done", {31'h0, st_done}, 32'h1);

        // Misaligned SW
        req(32'h101, 32'hAABBCCDD, 3'b010);
`ifdef MISALIGN_SPLIT_EN
        chk("mis_busy_t", {31'h0, st_busy}, 32'h1);
        tick();
        st_req = 1'b0;
        $display("txn SW-split1 addr=%h be=%b wdata=%h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
        chk("split1_addr", bus.mem_addr, 32'h100);
        chk("split1_be", {28'h0, bus.mem_be}, 32'hE);
        chk("split1_wdata", {8'h0, bus.mem_wdata[31:8]}, 32'h00BBCCDD);
        tick();
        $display("txn SW-split2 addr=%h be=%b wdata=%h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
        chk("split2_addr", bus.mem_addr, 32'h104);
        chk("split2_be", {28'h0, bus.mem_be}, 32'h1);
        chk("split2_wdata", {24'h0, bus.mem_wdata[7:0]}, 32'hAA);
        chk("split2_nodone", {31'h0, st_done}, 32'h0);
        tick();
        chk("split_done", {29'h0, st_done, st_err, bus.mem_valid}, 32'h4);
        tick();
        chk("split_done_pulse", {31'h0, st_done}, 32'h0);
`else
        chk("mis_busy_t", {31'h0, st_busy}, 32'h0);
        tick();
        st_req = 1'b0;
        $display("txn SW-misaligned err=%b valid=%b", st_err, bus.mem_valid);
        chk("mis_err", {29'h0, st_err, st_done, bus.mem_valid}, 32'h4);
        chk("mis_busy", {31'h0, st_busy}, 32'h0);
        tick();
        chk("mis_err_pulse", {30'h0, st_err, bus.mem_valid}, 32'h0);
`endif

        // Timeout with mem_ready held low
        bus.mem_ready = 1'b0;
        req(32'h300, 32'h00000001, 3'b010);
        tick();
        st_req = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.mem_valid) break;
            nvalid++;
            tick();
        end
        $display("txn SW-timeout valid_cycles=%0d err=%b", nvalid, st_err);
        chk("to_cycles", nvalid, 32'd16);
        chk("to_err", {30'h0, st_err, st_done}, 32'h2);
        chk("to_busy", {31'h0, st_busy}, 32'h0);
        tick();
        chk("to_err_pulse", {31'h0, st_err}, 32'h0);
        bus.mem_ready = 1'b1;
        req(32'h104, 32'h00000055, 3'b010);
        tick();
        st_req = 1'b0;
        chk("after_to_addr", bus.mem_addr, 32'h104);
        tick();
        $display("txn SW-after-timeout done=%b", st_done);
        chk("after_to_done", {31'h0, st_done}, 32'h1);

        // Delayed ready with a second request during busy
        bus.mem_ready = 1'b0;
        hs_base = hs_cnt;
        req(32'h10C, 32'hCAFEF00D, 3'b010);
        tick();
        st_addr = 32'h200;
        st_data = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                st_req = 1'b0;
                bus.mem_ready = 1'b1;
            end
            #1;
            chk("dly_valid", {31'h0, bus.mem_valid}, 32'h1);
            chk("dly_addr", bus.mem_addr, 32'h10C);
            chk("dly_wdata", bus.mem_wdata, 32'hCAFEF00D);
            chk("dly_be", {28'h0, bus.mem_be}, 32'hF);
            tick();
        end
        $display("txn SW-delayed done=%b", st_done);
        chk("dly_done", {31'h0, st_done}, 32'h1);
        tick();
        chk("dly_idle", {31'h0, bus.mem_valid}, 32'h0);
        chk("dly_one_hs", hs_cnt - hs_base, 32'd1);

        // Reset during the second ISSUE cycle
        bus.mem_ready = 1'b0;
        req(32'h400, 32'h87654321, 3'b010);
        tick();
        st_req = 1'b0;
        tick();
        chk("rstmid_valid_pre", {31'h0, bus.mem_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        $display("txn SW-reset valid=%b done=%b err=%b", bus.mem_valid, st_done, st_err);
        chk("rstmid_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("rstmid_addr", bus.mem_addr, 32'h0);
        chk("rstmid_wdata", bus.mem_wdata, 32'h0);
        chk("rstmid_be_flags", {26'h0, bus.mem_be, st_done, st_err}, 32'h0);
        tick();
        chk("rstmid_after", {29'h0, st_done, st_err, bus.mem_valid}, 32'h0);

        // Illegal funct3
        bus.mem_ready = 1'b1;
        req(32'h500, 32'h0, 3'b011);
        chk("ill_busy", {31'h0, st_busy}, 32'h0);
        tick();
        st_req = 1'b0;
        $display("txn ILLEGAL err=%b valid=%b", st_err, bus.mem_valid);
        chk("ill_err", {29'h0, st_err, st_done, bus.mem_valid}, 32'h4);
        tick();
        chk("ill_err_pulse", {30'h0, st_err, bus.mem_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-side counterpart to the load datapath: takes a store request from the core (address from the ALU, data from register port RD2, funct3) and writes it to data memory.
- Writes go over a valid/ready bus with byte enables.
- Holds the core in stall (st_busy) until the memory accepts the write.
- Reports misaligned/illegal stores and memory timeouts.

Parameters:
- TIMEOUT_CYC, 16: consecutive cycles with mem_valid=1 and mem_ready=0 before an issue is aborted; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- st_req  input  1  store request from core (MemWrite); sampled only in IDLE
- st_addr  input  32  byte address of the store
- st_data  input  32  store data (rs2)
- st_funct3  input  3  000=SB, 001=SH, 010=SW; any other value is illegal
- st_busy  output  1  combinational stall to PC/core
- st_done  output  1  one-cycle pulse: store completed
- st_err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- mem_valid  output  1  write request valid
- mem_ready  input  1  memory accepts write
- mem_addr  output  32  word-aligned address, bits [1:0] always 00
- mem_wdata  output  32  lane-replicated write data
- mem_be  output  4  byte enables, bit i corresponds to bits [8i+7:8i]

Behaviour:
- Reset values: state=IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, st_done=0, st_err=0, timeout counter=0.
- Reset mid-operation: mem_valid drops at the next edge; no st_done or st_err is generated.
- States: IDLE, ISSUE, ISSUE2 (ISSUE2 exists only with the optional feature).
- IDLE, st_req=1 at edge T:
  - Legal request: capture mem_addr, mem_wdata, mem_be. At T+1 go to ISSUE with mem_valid=1.
  - Misaligned or illegal funct3: no bus cycle. st_err=1 at T+1 for one cycle; stay in IDLE.
- ISSUE:
  - mem_valid stays 1. mem_addr, mem_wdata, mem_be are held stable until the handshake.
  - Handshake at edge H (mem_valid & mem_ready): at H+1 mem_valid=0, st_done=1 for one cycle, state=IDLE.
- Timeout: counter increments on each ISSUE/ISSUE2 cycle without mem_ready and clears on handshake. When the count reaches TIMEOUT_CYC: mem_valid=0, st_err=1 for one cycle, state=IDLE, no st_done.
- st_busy = (state != IDLE) | (state==IDLE & st_req & legal request).
  - Busy from T through the handshake cycle; low in the st_done cycle.
  - A misaligned request in IDLE without the optional feature does not assert st_busy.
- st_req is ignored when state != IDLE.
- Lane rules, with a = st_addr[1:0]:
  - SB: mem_be = 1<<a; mem_wdata = {4{st_data[7:0]}}.
  - SH: legal when a[0]=0; mem_be = a[1] ? 1100 : 0011; mem_wdata = {2{st_data[15:0]}}.
  - SW: legal when a=00; mem_be = 1111; mem_wdata = st_data.
- mem_addr = {st_addr[31:2], 2'b00}.
- st_done and st_err are never high in the same cycle.

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined:
  - A misaligned SH/SW is split into two aligned writes.
  - First write (ISSUE): base word, lanes a..3 take the low bytes of the shifted data.
  - Second write (ISSUE2): base+4, wrapping 0xFFFFFFFC+4 -> 0x00000000; lanes 0..(a+size-5) take the remaining bytes.
  - st_done fires only after the second handshake. A timeout in either phase aborts the store with st_err.
  - Illegal funct3 still produces st_err.
- Undefined: misaligned stores produce st_err with no bus traffic; ISSUE2 is not built.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, mem_ready high from the first valid cycle -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF; st_done exactly 2 cycles after st_req; st_busy high 2 cycles.
- SB addr=0x203, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, mem_addr=0x200. SH addr=0x202, data=0x1234 -> be=1100, wdata=0x12341234.
- SW addr=0x101 without the macro -> st_err pulse at T+1, mem_valid never rises, st_busy stays low. With MISALIGN_SPLIT_EN and data=0xAABBCCDD:
  - First write: 0x100, be=1110, wdata[31:8]=0xBBCCDD.
  - Second write: 0x104, be=0001, wdata[7:0]=0xAA.
  - One st_done pulse.
- mem_ready held 0 with TIMEOUT_CYC=16 -> mem_valid high exactly 16 cycles, then st_err pulse, state IDLE; a following SW completes normally.
- mem_ready delayed 3 cycles -> addr/wdata/be stable across all 4 valid cycles. A second st_req during busy is ignored (only one handshake).
- rst asserted in the 2nd ISSUE cycle -> mem_valid=0 at the next edge, all outputs at reset values, no st_done/st_err. funct3=011 -> st_err, no bus cycle.
